// File: rtl/ones_counter.sv
// Registered 8-bay occupancy counter: popcount of new_capacity with free/full/empty
// flags (compiled in only when ONES_COUNTER_FLAGS_EN is defined) and a change strobe.
module ones_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] new_capacity,
  input  logic       in_valid,
  output logic [3:0] parked,
  output logic [3:0] free,
  output logic       full,
  output logic       empty,
  output logic       out_valid,
  output logic       changed
);

  // Handshake: a sample is taken on every rising edge with in_valid=1 (no ready,
  // no backpressure); out_valid pulses for exactly one cycle per accepted sample.

  logic [1:0] pair_sum [4];
  logic [2:0] quad_sum [2];
  logic [3:0] count;

  // Adder tree: bit pairs, then pairs of pairs, then the final sum (max 8, no truncation).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pair_sum[i] = {1'b0, new_capacity[2*i]} + {1'b0, new_capacity[2*i+1]};
    end
    for (int j = 0; j < 2; j++) begin
      quad_sum[j] = {1'b0, pair_sum[2*j]} + {1'b0, pair_sum[2*j+1]};
    end
    count = {1'b0, quad_sum[0]} + {1'b0, quad_sum[1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parked    <= 4'd0;
      out_valid <= 1'b0;
      changed   <= 1'b0;
    end else if (in_valid) begin
      parked    <= count;
      out_valid <= 1'b1;
      changed   <= (count != parked);
    end else begin
      out_valid <= 1'b0;
      changed   <= 1'b0;
    end
  end

`ifdef ONES_COUNTER_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      free  <= 4'd8;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (in_valid) begin
      free  <= 4'd8 - count;
      full  <= (count == 4'd8);
      empty <= (count == 4'd0);
    end
  end
`else
  assign free  = 4'd0;
  assign full  = 1'b0;
  assign empty = 1'b0;
`endif

endmodule

// File: tb/tb_ones_counter.sv
// Self-checking bench for ones_counter: reset, directed table, multi-cycle
// sequences and randomized traffic against a bit-counting reference model.
module tb_ones_counter;

  logic       clk;
  logic       rst_n;
  logic [7:0] new_capacity;
  logic       in_valid;
  logic [3:0] parked;
  logic [3:0] free;
  logic       full;
  logic       empty;
  logic       out_valid;
  logic       changed;

  int total = 0;
  int bad   = 0;

  // Reference model state: what the outputs should show after the last edge.
  int m_parked = 0;
  int m_ov     = 0;
  int m_ch     = 0;
  logic [3:0] exp_q[$];

  ones_counter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_capacity (new_capacity),
    .in_valid     (in_valid),
    .parked       (parked),
    .free         (free),
    .full         (full),
    .empty        (empty),
    .out_valid    (out_valid),
    .changed      (changed)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bits_set(input logic [7:0] v);
    int n = 0;
    for (int k = 0; k < 8; k++) if (v[k]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, compare every output.
  task automatic apply(input logic [7:0] cap, input logic vld, input logic rst);
    int n;
    new_capacity = cap;
    in_valid     = vld;
    rst_n        = ~rst;
    n = bits_set(cap);
    if (rst) begin
      m_parked = 0; m_ov = 0; m_ch = 0;
    end else if (vld) begin
      m_ch = (n != m_parked) ? 1 : 0;
      m_parked = n;
      m_ov = 1;
      exp_q.push_back(4'(n));
    end else begin
      m_ov = 0; m_ch = 0;
    end
    @(posedge clk);
    #1;
    chk("parked", int'(parked), m_parked);
    chk("out_valid", int'(out_valid), m_ov);
    chk("changed", int'(changed), m_ch);
`ifdef ONES_COUNTER_FLAGS_EN
    chk("free", int'(free), 8 - m_parked);
    chk("full", int'(full), (m_parked == 8) ? 1 : 0);
    chk("empty", int'(empty), (m_parked == 0) ? 1 : 0);
`else
    chk("free", int'(free), 0);
    chk("full", int'(full), 0);
    chk("empty", int'(empty), 0);
`endif
    if (m_ov == 1) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
      else chk("scoreboard", int'(parked), int'(exp_q.pop_front()));
    end
    chk("sum_invariant", int'(parked) + int'(free),
`ifdef ONES_COUNTER_FLAGS_EN
        8
`else
        m_parked
`endif
    );
  endtask

  typedef struct {
    logic [7:0] cap;
    int         exp_parked;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'b0000_0000, 0};
    vecs[1] = '{8'b1111_0000, 4};
    vecs[2] = '{8'b1111_1111, 8};
    vecs[3] = '{8'b0000_0001, 1};
    vecs[4] = '{8'b0001_0001, 2};
    vecs[5] = '{8'b0011_0011, 4};
    vecs[6] = '{8'b0101_1001, 4};
    vecs[7] = '{8'b1010_1010, 4};

    rst_n = 1'b0; in_valid = 1'b0; new_capacity = 8'h00;

    // Reset held two cycles with a valid all-ones sample present
    apply(8'hFF, 1'b1, 1'b1);
    apply(8'hFF, 1'b1, 1'b1);

    // Directed table; first sample counts 0 so changed must stay 0
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].cap, 1'b1, 1'b0);
      chk("table_parked", int'(parked), vecs[i].exp_parked);
    end

    // Flags at both extremes
    apply(8'hFF, 1'b1, 1'b0);
    apply(8'h00, 1'b1, 1'b0);

    // Change strobe: equal counts then a different count
    apply(8'b0011_0011, 1'b1, 1'b0);
    apply(8'b1100_1100, 1'b1, 1'b0);
    chk("changed_equal", int'(changed), 0);
    apply(8'b0000_0111, 1'b1, 1'b0);
    chk("changed_diff", int'(changed), 1);
    chk("parked_three", int'(parked), 3);

    // Hold: invalid cycles with all-ones present must not disturb parked
    apply(8'b0000_1111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(8'hFF, 1'b0, 1'b0);
      chk("hold_parked", int'(parked), 4);
    end

    // Reset then first nonzero sample must strobe changed
    apply(8'h00, 1'b0, 1'b1);
    apply(8'b0000_0010, 1'b1, 1'b0);
    chk("first_after_reset", int'(changed), 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      apply(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ones_counter.md
# ones_counter

Registered population-count stage for the parking occupancy path. Each of the 8 bits of `new_capacity` is one bay sensor, with 1 meaning occupied. On every valid sample the block counts the set bits and registers the result on `parked`. It also provides a free-bay count, full/empty flags and a change strobe to the downstream display and gate logic.

## Interface
Parameters:
- none. Width is fixed at 8 bays; count width is 4 bits.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low; sampled on the `clk` rising edge.
- `new_capacity`  input  8  bay occupancy vector; bit i = 1 means bay i is occupied.
- `in_valid`  input  1  `new_capacity` is sampled on edges where this is 1.
- `parked`  output  4  registered count of ones in the last sampled `new_capacity`, range 0..8.
- `free`  output  4  registered value of 8 − `parked`.
- `full`  output  1  registered; 1 when `parked` == 8.
- `empty`  output  1  registered; 1 when `parked` == 0.
- `out_valid`  output  1  one-cycle pulse: new result on outputs this cycle.
- `changed`  output  1  one-cycle pulse: new result differs from the previous `parked`.

## Operation
- Count = sum of `new_capacity[7:0]`, computed combinationally as an adder tree: four 2-bit pair sums → two 3-bit sums → one 4-bit sum. No truncation; 8 ones yields 4'd8.
- On a `clk` edge with `rst_n`=1 and `in_valid`=1:
  - `parked` ← count; `free` ← 8 − count.
  - `full` ← (count == 8); `empty` ← (count == 0).
  - `out_valid` ← 1; `changed` ← (count != current `parked`).
- On a `clk` edge with `rst_n`=1 and `in_valid`=0:
  - `parked`, `free`, `full` and `empty` hold their values.
  - `out_valid` ← 0; `changed` ← 0.
- No internal state besides the output registers. There is no FSM.
- Any bit pattern is legal input. Only the number of set bits matters, not their positions.
- Invariant at all times: `parked` + `free` == 8 (when flags are compiled in).

## Timing
- Latency: 1 cycle from an `in_valid` edge to the updated outputs. There is no backpressure and a new sample is accepted every cycle.
- Reset (`rst_n`=0 at a rising edge) takes priority over `in_valid`. Values after reset:
  - `parked`=0.
  - `free`=8, `full`=0, `empty`=1 (when flags are compiled in).
  - `out_valid`=0, `changed`=0.
- Reset asserted while `in_valid`=1: the sample is discarded and the reset values are loaded.
- First valid sample after reset: `changed`=1 only if the count is nonzero.
- Back-to-back valid samples with equal counts: `out_valid` stays 1 on each cycle and `changed`=0.
- Outputs change only on `clk` edges. `new_capacity` and `in_valid` have no combinational path to any output.

## Configuration
- Macro: `ONES_COUNTER_FLAGS_EN`.
- Defined:
  - `free`, `full` and `empty` are registered and behave as described above.
- Undefined:
  - `free`, `full` and `empty` are tied to constant 0, including during and after reset.
  - Their registers and the subtractor are removed.
  - Ports remain present, so instantiations do not change.
  - `parked`, `out_valid` and `changed` are unaffected.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 and `new_capacity`=8'hFF → `parked`=0, `free`=8, `empty`=1, `full`=0, `out_valid`=0.
- Directed sweep, one sample per cycle with `in_valid`=1, checking `parked` one cycle later:

  | `new_capacity` | `parked` |
  |---|---|
  | 8'b0000_0000 | 0 |
  | 8'b1111_0000 | 4 |
  | 8'b1111_1111 | 8 |
  | 8'b0000_0001 | 1 |
  | 8'b0001_0001 | 2 |
  | 8'b0011_0011 | 4 |
  | 8'b0101_1001 | 4 |
  | 8'b1010_1010 | 4 |

  Also check `free` = 8 − `parked` on every sample.
- Flags: 8'hFF → `full`=1, `empty`=0, `free`=0. Then 8'h00 → `full`=0, `empty`=1, `free`=8.
- Change strobe: samples 8'b0011_0011 then 8'b1100_1100 → `changed`=0 on the second (both count 4). Then 8'b0000_0111 → `changed`=1 and `parked`=3.
- Hold: apply a valid 8'b0000_1111, then `in_valid`=0 with `new_capacity`=8'hFF for 3 cycles → `parked` stays 4, `out_valid`=0, `changed`=0.
- Build with `ONES_COUNTER_FLAGS_EN` undefined and rerun the sweep → `parked` is identical; `free`, `full` and `empty` are constantly 0.
